// File: rtl/proj_pkg.sv
// Shared types and helpers for the vertex projector: FSM states, product
// width and the unsigned pixel-range saturation used on the output stage.
package proj_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_DIV  = 3'd1,
    ST_MUL  = 3'd2,
    ST_OUT  = 3'd3,
    ST_HOLD = 3'd4
  } state_e;

  localparam int SAT_W = 64;

  function automatic int prod_width(input int coord_w, input int div_w);
    return coord_w + div_w + 1;
  endfunction

  function automatic logic [SAT_W-1:0] out_max(input int out_w);
    return (64'd1 << out_w) - 64'd1;
  endfunction

  function automatic logic off_range(input logic signed [SAT_W-1:0] v, input int out_w);
    return (v < 64'sd0) || (v > $signed(out_max(out_w)));
  endfunction

  function automatic logic [31:0] saturate(input logic signed [SAT_W-1:0] v, input int out_w);
    logic [SAT_W-1:0] hi;
    hi = out_max(out_w);
    if (v < 64'sd0) return '0;
    if (v > $signed(hi)) return hi[31:0];
    return v[31:0];
  endfunction

endpackage

// File: rtl/vertex_proj_if.sv
// Vertex stream handshake between transform stage, projector and triangle setup.
interface vertex_proj_if #(
  parameter int COORD_W = 16,
  parameter int OUT_W   = 9
);
  logic                      valid_in;
  logic                      ready_out;
  logic [2:0][COORD_W-1:0]   coor_in;
  logic                      obj_done_in;
  logic [2:0][OUT_W-1:0]     coor_out;
  logic                      clip_out;
  logic                      valid_out;
  logic                      obj_done_out;
  logic                      ready_in;

  modport slave (
    input  valid_in, coor_in, obj_done_in, ready_in,
    output ready_out, coor_out, clip_out, valid_out, obj_done_out
  );

  modport master (
    output valid_in, coor_in, obj_done_in, ready_in,
    input  ready_out, coor_out, clip_out, valid_out, obj_done_out
  );
endinterface

// File: rtl/seq_divider.sv
// Unsigned restoring divider, one quotient bit per cycle; the start cycle
// already resolves the first bit, so done pulses DIV_W cycles after start.
module seq_divider #(
  parameter int DIV_W = 32
) (
  input  logic             clk_in,
  input  logic             rst_in,
  input  logic             start,
  input  logic [DIV_W-1:0] dividend,
  input  logic [DIV_W-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [DIV_W-1:0] quotient
);
  localparam int CNT_W = $clog2(DIV_W + 1);

  logic [DIV_W-1:0] rem_q, rem_d, quo_q, quo_d, dvs_q, dvs_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             busy_q, busy_d, done_q, done_d;
  logic [DIV_W-1:0] src_rem, src_quo;
  logic [DIV_W:0]   trial;
  logic             take;

  always_comb begin
    src_rem = start ? '0 : rem_q;
    src_quo = start ? dividend : quo_q;
    dvs_d   = start ? divisor : dvs_q;
    trial   = {src_rem, src_quo[DIV_W-1]};
    take    = trial >= {1'b0, dvs_d};
    rem_d   = rem_q;
    quo_d   = quo_q;
    cnt_d   = cnt_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    // Dividend bits shift out of the top while quotient bits fill from below.
    if (start || busy_q) begin
      rem_d = take ? DIV_W'(trial - {1'b0, dvs_d}) : trial[DIV_W-1:0];
      quo_d = {src_quo[DIV_W-2:0], take};
    end
    if (start) begin
      cnt_d  = CNT_W'(DIV_W - 1);
      busy_d = 1'b1;
    end else if (busy_q) begin
      cnt_d = cnt_q - CNT_W'(1);
      if (cnt_q == CNT_W'(1)) begin
        busy_d = 1'b0;
        done_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      rem_q  <= '0;
      quo_q  <= '0;
      dvs_q  <= '0;
      cnt_q  <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      rem_q  <= rem_d;
      quo_q  <= quo_d;
      dvs_q  <= dvs_d;
      cnt_q  <= cnt_d;
      busy_q <= busy_d;
      done_q <= done_d;
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign quotient = quo_q;

endmodule

// File: rtl/vertex_proj.sv
// Fixed-point perspective projector: screen = C + FOCAL*coord/z using one
// shared reciprocal per vertex, with near-plane rejection and clip policy.
//   state | meaning
//   IDLE  | ready for a vertex; near check and divider start on accept
//   DIV   | reciprocal FOCAL*2^R_FRAC/z in progress
//   MUL   | scale x and y by the reciprocal
//   OUT   | phase 0 forms clipped/saturated results, phase 1 publishes them
//   HOLD  | result valid, waiting for downstream ready
module vertex_proj
  import proj_pkg::*;
#(
  parameter int COORD_W   = 16,
  parameter int FRAC_W    = 6,
  parameter int OUT_W     = 9,
  parameter int FOCAL     = 900,
  parameter int CX        = 180,
  parameter int CY        = 180,
  parameter int R_FRAC    = 16,
  parameter int DIV_W     = 32,
  parameter int NEAR_Z    = 64,
  parameter int CLIP_MODE = 0
) (
  input logic          clk_in,
  input logic          rst_in,
  vertex_proj_if.slave io
);
  localparam int PROD_W = prod_width(COORD_W, DIV_W);
  localparam logic [DIV_W-1:0] DIVIDEND = DIV_W'(FOCAL) << R_FRAC;

  if ((64'(FOCAL) << R_FRAC) >= (64'd1 << DIV_W) || NEAR_Z < 1 || OUT_W > 32 ||
      DIV_W <= COORD_W) begin : g_param_check
    $error("vertex_proj: illegal parameter combination");
  end

  state_e                     state_q, state_d;
  logic                       ready_q, ready_d, valid_q, valid_d;
  logic                       clip_q, clip_d, odone_q, odone_d;
  logic                       obj_q, obj_d, near_q, near_d, ph_q, ph_d;
  logic signed [COORD_W-1:0]  x_q, x_d, y_q, y_d, z_q, z_d;
  logic signed [PROD_W-1:0]   px_q, px_d, py_q, py_d;
  logic [2:0][OUT_W-1:0]      coor_q, coor_d;

  logic                       div_start, div_done, div_busy_unused;
  logic [DIV_W-1:0]           quot;
  logic signed [PROD_W-1:0]   prod_x, prod_y;
  logic signed [PROD_W:0]     sx, sy;
  logic signed [COORD_W-1:0]  z_int;
  logic [31:0]                sat_x, sat_y, sat_z;
  logic                       off, near_in;
  logic                       unused_sat;

  seq_divider #(.DIV_W(DIV_W)) u_div (
    .clk_in   (clk_in),
    .rst_in   (rst_in),
    .start    (div_start),
    .dividend (DIVIDEND),
    .divisor  ({{(DIV_W-COORD_W){1'b0}}, io.coor_in[0]}),
    .busy     (div_busy_unused),
    .done     (div_done),
    .quotient (quot)
  );

  always_comb begin
    state_d   = state_q;
    ready_d   = ready_q;
    valid_d   = valid_q;
    clip_d    = clip_q;
    odone_d   = odone_q;
    obj_d     = obj_q;
    near_d    = near_q;
    ph_d      = ph_q;
    x_d       = x_q;
    y_d       = y_q;
    z_d       = z_q;
    px_d      = px_q;
    py_d      = py_q;
    coor_d    = coor_q;
    div_start = 1'b0;

    near_in = SAT_W'($signed(io.coor_in[0])) <= SAT_W'(NEAR_Z);
    prod_x  = $signed(PROD_W'(x_q)) * $signed(PROD_W'({1'b0, quot}));
    prod_y  = $signed(PROD_W'(y_q)) * $signed(PROD_W'({1'b0, quot}));
    sx      = $signed({px_q[PROD_W-1], px_q}) + $signed((PROD_W+1)'(CX));
    sy      = $signed({py_q[PROD_W-1], py_q}) + $signed((PROD_W+1)'(CY));
    z_int   = z_q >>> FRAC_W;
    sat_x   = saturate(SAT_W'(sx), OUT_W);
    sat_y   = saturate(SAT_W'(sy), OUT_W);
    sat_z   = saturate(SAT_W'(z_int), OUT_W);
    off     = off_range(SAT_W'(sx), OUT_W) || off_range(SAT_W'(sy), OUT_W);

    case (state_q)
      ST_IDLE: begin
        ready_d = 1'b1;
        if (io.valid_in && ready_q) begin
          x_d     = $signed(io.coor_in[2]);
          y_d     = $signed(io.coor_in[1]);
          z_d     = $signed(io.coor_in[0]);
          obj_d   = io.obj_done_in;
          near_d  = near_in;
          ph_d    = 1'b0;
          ready_d = 1'b0;
          if (near_in) begin
            state_d = ST_OUT;
          end else begin
            div_start = 1'b1;
            state_d   = ST_DIV;
          end
        end
      end
      ST_DIV: begin
        if (div_done) state_d = ST_MUL;
      end
      ST_MUL: begin
        px_d    = prod_x >>> R_FRAC;
        py_d    = prod_y >>> R_FRAC;
        state_d = ST_OUT;
      end
      ST_OUT: begin
        if (!ph_q) begin
          ph_d = 1'b1;
          if (near_q) begin
            coor_d[2] = OUT_W'(CX);
            coor_d[1] = OUT_W'(CY);
            coor_d[0] = '0;
            clip_d    = 1'b1;
          end else begin
            coor_d[2] = (CLIP_MODE == 0) ? sat_x[OUT_W-1:0] : sx[OUT_W-1:0];
            coor_d[1] = (CLIP_MODE == 0) ? sat_y[OUT_W-1:0] : sy[OUT_W-1:0];
            coor_d[0] = sat_z[OUT_W-1:0];
            clip_d    = off;
          end
        end else begin
          ph_d    = 1'b0;
          valid_d = 1'b1;
          odone_d = obj_q;
          state_d = ST_HOLD;
        end
      end
      ST_HOLD: begin
        if (io.ready_in) begin
          valid_d = 1'b0;
          ready_d = 1'b1;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state_q <= ST_IDLE;
      ready_q <= 1'b0;
      valid_q <= 1'b0;
      clip_q  <= 1'b0;
      odone_q <= 1'b0;
      obj_q   <= 1'b0;
      near_q  <= 1'b0;
      ph_q    <= 1'b0;
      x_q     <= '0;
      y_q     <= '0;
      z_q     <= '0;
      px_q    <= '0;
      py_q    <= '0;
      coor_q  <= '0;
    end else begin
      state_q <= state_d;
      ready_q <= ready_d;
      valid_q <= valid_d;
      clip_q  <= clip_d;
      odone_q <= odone_d;
      obj_q   <= obj_d;
      near_q  <= near_d;
      ph_q    <= ph_d;
      x_q     <= x_d;
      y_q     <= y_d;
      z_q     <= z_d;
      px_q    <= px_d;
      py_q    <= py_d;
      coor_q  <= coor_d;
    end
  end

  assign unused_sat      = ^{sat_x, sat_y, sat_z};
  assign io.ready_out    = ready_q;
  assign io.valid_out    = valid_q;
  assign io.coor_out     = coor_q;
  assign io.clip_out     = clip_q;
  assign io.obj_done_out = odone_q;

endmodule

// File: tb/tb_vertex_proj.sv
// Bench for vertex_proj: both clip policies driven in lockstep and compared
// against an arithmetic projection model.
module tb_vertex_proj;
  localparam int FOCAL  = 900;
  localparam int CXY    = 180;
  localparam int NEAR_Z = 64;
  localparam int PIXMAX = 511;
  localparam int LAT_N  = 35;
  localparam int LAT_NR = 2;

  logic clk_in = 1'b0;
  logic rst_in = 1'b0;
  always #5 clk_in = ~clk_in;

  vertex_proj_if #(.COORD_W(16), .OUT_W(9)) bus0 ();
  vertex_proj_if #(.COORD_W(16), .OUT_W(9)) bus1 ();

  vertex_proj #(.CLIP_MODE(0)) dut0 (.clk_in(clk_in), .rst_in(rst_in), .io(bus0.slave));
  vertex_proj #(.CLIP_MODE(1)) dut1 (.clk_in(clk_in), .rst_in(rst_in), .io(bus1.slave));

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic longint floor_div(input longint a, input longint b);
    longint q;
    q = a / b;
    if ((a % b != 0) && (a < 0)) q = q - 1;
    return q;
  endfunction

  function automatic longint clamp_pix(input longint v);
    if (v < 0) return 0;
    if (v > PIXMAX) return PIXMAX;
    return v;
  endfunction

  task automatic model(input int x, input int y, input int z, input int mode,
                       output longint ox, output longint oy, output longint oz,
                       output longint oc);
    longint r, sx, sy;
    if (z <= NEAR_Z) begin
      ox = CXY; oy = CXY; oz = 0; oc = 1;
    end else begin
      r  = (longint'(FOCAL) * 65536) / z;
      sx = floor_div(longint'(x) * r, 65536) + CXY;
      sy = floor_div(longint'(y) * r, 65536) + CXY;
      oc = (sx < 0 || sx > PIXMAX || sy < 0 || sy > PIXMAX) ? 1 : 0;
      ox = (mode == 0) ? clamp_pix(sx) : (sx & PIXMAX);
      oy = (mode == 0) ? clamp_pix(sy) : (sy & PIXMAX);
      oz = clamp_pix(longint'(z) / 64);
    end
  endtask

  task automatic drive_in(input logic v, input int x, input int y, input int z, input logic od);
    bus0.valid_in    = v;
    bus0.coor_in     = {16'(x), 16'(y), 16'(z)};
    bus0.obj_done_in = od;
    bus1.valid_in    = v;
    bus1.coor_in     = {16'(x), 16'(y), 16'(z)};
    bus1.obj_done_in = od;
  endtask

  task automatic set_ready(input logic r);
    bus0.ready_in = r;
    bus1.ready_in = r;
  endtask

  task automatic check_out(input string tag, input int x, input int y, input int z, input logic od);
    longint ox, oy, oz, oc;
    model(x, y, z, 0, ox, oy, oz, oc);
    check({tag, ".sx0"}, 64'(bus0.coor_out[2]), ox);
    check({tag, ".sy0"}, 64'(bus0.coor_out[1]), oy);
    check({tag, ".z0"},  64'(bus0.coor_out[0]), oz);
    check({tag, ".clip0"}, 64'(bus0.clip_out), oc);
    check({tag, ".od0"}, 64'(bus0.obj_done_out), 64'(od));
    model(x, y, z, 1, ox, oy, oz, oc);
    check({tag, ".sx1"}, 64'(bus1.coor_out[2]), ox);
    check({tag, ".sy1"}, 64'(bus1.coor_out[1]), oy);
    check({tag, ".z1"},  64'(bus1.coor_out[0]), oz);
    check({tag, ".clip1"}, 64'(bus1.clip_out), oc);
    check({tag, ".od1"}, 64'(bus1.obj_done_out), 64'(od));
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, ".valid"}, 64'({bus0.valid_out, bus1.valid_out}), 0);
    check({tag, ".ready"}, 64'({bus0.ready_out, bus1.ready_out}), 0);
    check({tag, ".coor0"}, 64'(bus0.coor_out), 0);
    check({tag, ".coor1"}, 64'(bus1.coor_out), 0);
    check({tag, ".clip"},  64'({bus0.clip_out, bus1.clip_out}), 0);
    check({tag, ".od"},    64'({bus0.obj_done_out, bus1.obj_done_out}), 0);
  endtask

  task automatic wait_ready(input string tag);
    int n;
    n = 0;
    while (!(bus0.ready_out && bus1.ready_out) && n < 100) begin
      @(negedge clk_in);
      n++;
    end
    if (n >= 100) check({tag, ".ready_timeout"}, 64'(n), 0);
  endtask

  task automatic run_vertex(input string tag, input int x, input int y, input int z,
                            input logic od, input int stall);
    int lat;
    wait_ready(tag);
    drive_in(1'b1, x, y, z, od);
    set_ready(1'b0);
    @(posedge clk_in);
    @(negedge clk_in);
    drive_in(1'b0, int'($urandom), int'($urandom), int'($urandom), 1'($urandom));
    lat = 0;
    while (!bus0.valid_out && lat < 100) begin
      @(posedge clk_in);
      lat++;
      @(negedge clk_in);
    end
    check({tag, ".latency"}, 64'(lat), (z <= NEAR_Z) ? 64'(LAT_NR) : 64'(LAT_N));
    check({tag, ".valid1"}, 64'(bus1.valid_out), 1);
    check_out(tag, x, y, z, od);
    for (int i = 0; i < stall; i++) begin
      @(posedge clk_in);
      @(negedge clk_in);
      check({tag, ".hold_valid"}, 64'({bus0.valid_out, bus1.valid_out}), 3);
      check({tag, ".hold_ready"}, 64'({bus0.ready_out, bus1.ready_out}), 0);
      check_out({tag, ".hold"}, x, y, z, od);
    end
    set_ready(1'b1);
    @(posedge clk_in);
    @(negedge clk_in);
    set_ready(1'b0);
    check({tag, ".post_valid"}, 64'({bus0.valid_out, bus1.valid_out}), 0);
    check({tag, ".post_ready"}, 64'({bus0.ready_out, bus1.ready_out}), 3);
  endtask

  initial begin
    int cnt, x, y, z;
    logic od;
    drive_in(1'b0, 0, 0, 0, 1'b0);
    set_ready(1'b0);
    #2 rst_in = 1'b1;
    #1 check_all_zero("reset");
    repeat (3) @(negedge clk_in);
    rst_in = 1'b0;
    check("reset.ready_low", 64'({bus0.ready_out, bus1.ready_out}), 0);
    @(posedge clk_in);
    @(negedge clk_in);
    check("reset.ready_rise", 64'({bus0.ready_out, bus1.ready_out}), 3);

    run_vertex("basic", 64, -64, 320, 1'b0, 0);
    run_vertex("sat", 128, 0, 320, 1'b0, 0);
    run_vertex("near", 0, 0, 32, 1'b1, 5);
    run_vertex("b2b", -128, 96, 640, 1'b0, 0);

    // abort a vertex mid-divide; the earlier near result must vanish
    run_vertex("pre_rst", 10, 10, -5, 1'b1, 0);
    wait_ready("rst_mid");
    drive_in(1'b1, 64, 64, 320, 1'b1);
    @(posedge clk_in);
    @(negedge clk_in);
    drive_in(1'b0, 0, 0, 0, 1'b0);
    repeat (10) @(posedge clk_in);
    #1 rst_in = 1'b1;
    #1 check_all_zero("rst_mid");
    @(negedge clk_in);
    @(negedge clk_in);
    rst_in = 1'b0;
    check("rst_mid.ready_low", 64'({bus0.ready_out, bus1.ready_out}), 0);
    @(posedge clk_in);
    @(negedge clk_in);
    check("rst_mid.ready_rise", 64'({bus0.ready_out, bus1.ready_out}), 3);
    cnt = 0;
    for (int i = 0; i < 45; i++) begin
      @(negedge clk_in);
      if (bus0.valid_out || bus1.valid_out) cnt++;
    end
    check("rst_mid.no_valid", 64'(cnt), 0);

    run_vertex("seq0", 200, -150, 400, 1'b0, int'($urandom_range(0, 4)));
    run_vertex("seq1", -300, 40, 900, 1'b0, int'($urandom_range(0, 4)));
    run_vertex("seq2", 50, 500, 130, 1'b1, int'($urandom_range(0, 4)));

    for (int k = 0; k < 20; k++) begin
      x  = int'($urandom_range(0, 1600)) - 800;
      y  = int'($urandom_range(0, 1600)) - 800;
      z  = int'($urandom_range(0, 1400)) - 100;
      od = 1'($urandom);
      run_vertex("rand", x, y, z, od, int'($urandom_range(0, 3)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
